// File: rtl/fb_pkg.sv
// Framebuffer geometry, pixel/colour types, the raster flag bundle and the fixed 16-colour palette.
package fb_pkg;

    localparam int unsigned FB_WIDTH  = 800;
    localparam int unsigned FB_HEIGHT = 480;
    localparam int unsigned FB_PIXELS = FB_WIDTH * FB_HEIGHT;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned PIX_W  = 4;
    localparam int unsigned RGB_W  = 12;
    localparam int unsigned BAR_W  = 3;

    typedef logic [ADDR_W-1:0] fb_addr_t;
    typedef logic [PIX_W-1:0]  pix_idx_t;
    typedef logic [RGB_W-1:0]  rgb_t;

    // Raw raster flags that travel alongside the framebuffer read latency
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic first;
    } scan_flags_t;

    localparam rgb_t PALETTE [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA,
        12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF,
        12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

endpackage

// File: rtl/fb_scanout_if.sv
// Framebuffer read port plus video output bundle; master = scanout side, slave = framebuffer/panel side.
interface fb_scanout_if;
    import fb_pkg::*;

    fb_addr_t addr_vga;
    pix_idx_t data_vga;
    logic     test_pattern;
    rgb_t     rgb;
    logic     de;
    logic     hsync;
    logic     vsync;
    logic     frame_start;

    modport master (
        output addr_vga, rgb, de, hsync, vsync, frame_start,
        input  data_vga, test_pattern
    );

    modport slave (
        input  addr_vga, rgb, de, hsync, vsync, frame_start,
        output data_vga, test_pattern
    );

endinterface

// File: rtl/fb_scanout_timing.sv
// Raster counters and raw active/sync/first-pixel flags for the scanout.
// With TEST_PATTERN_EN defined it also reports the colour-bar index of the current column.
module fb_scanout_timing
    import fb_pkg::*;
#(
    parameter int unsigned H_ACTIVE = FB_WIDTH,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = FB_HEIGHT,
    parameter int unsigned V_FP     = 13,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BP     = 29
) (
    input  logic             clock,
    input  logic             reset,
`ifdef TEST_PATTERN_EN
    output logic [BAR_W-1:0] o_bar_c,
`endif
    output logic             o_active_c,
    output logic             o_hsync_c,
    output logic             o_vsync_c,
    output logic             o_first_c
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;

    // Pixel/line counters; reset parks them on active pixel (0,0)
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (r_hcnt == HW'(H_TOTAL - 1)) begin
            r_hcnt <= '0;
            r_vcnt <= (r_vcnt == VW'(V_TOTAL - 1)) ? '0 : r_vcnt + VW'(1);
        end else begin
            r_hcnt <= r_hcnt + HW'(1);
        end
    end

    assign o_active_c = (r_hcnt < HW'(H_ACTIVE)) && (r_vcnt < VW'(V_ACTIVE));
    assign o_hsync_c  = (r_hcnt >= HW'(H_ACTIVE + H_FP)) &&
                        (r_hcnt <  HW'(H_ACTIVE + H_FP + H_SYNC));
    assign o_vsync_c  = (r_vcnt >= VW'(V_ACTIVE + V_FP)) &&
                        (r_vcnt <  VW'(V_ACTIVE + V_FP + V_SYNC));
    assign o_first_c  = (r_hcnt == '0) && (r_vcnt == '0);

`ifdef TEST_PATTERN_EN
    localparam int unsigned BAR_PIX = H_ACTIVE / 8;

    // Eight equal-width vertical bars across the visible line
    always_comb begin
        o_bar_c = '0;
        for (int i = 1; i < 8; i++) begin
            if (r_hcnt >= HW'(i * BAR_PIX)) o_bar_c = BAR_W'(i);
        end
    end
`endif

endmodule

// File: rtl/fb_scanout.sv
// Display-side framebuffer reader: raster timing, read-address generation, latency alignment and palette lookup.
// Optional colour-bar generator enabled by defining TEST_PATTERN_EN.
module fb_scanout
    import fb_pkg::*;
#(
    parameter int unsigned H_ACTIVE        = FB_WIDTH,
    parameter int unsigned H_FP            = 40,
    parameter int unsigned H_SYNC          = 128,
    parameter int unsigned H_BP            = 88,
    parameter int unsigned V_ACTIVE        = FB_HEIGHT,
    parameter int unsigned V_FP            = 13,
    parameter int unsigned V_SYNC          = 3,
    parameter int unsigned V_BP            = 29,
    parameter int unsigned FB_LATENCY      = 3,
    parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
    input  logic         clock,
    input  logic         reset,
    fb_scanout_if.master bus
);

    localparam int unsigned PIXELS   = H_ACTIVE * V_ACTIVE;
    localparam logic        SYNC_INV = (SYNC_ACTIVE_LOW != 0);

    scan_flags_t w_flags;
    scan_flags_t w_emerge;
    scan_flags_t r_pipe [FB_LATENCY];
    fb_addr_t    r_addr;
    rgb_t        w_rgb;
    rgb_t        r_rgb;
    logic        r_de;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_frame_start;

`ifdef TEST_PATTERN_EN
    logic [BAR_W-1:0] w_bar;
    logic [BAR_W-1:0] r_bar_pipe [FB_LATENCY];
`endif

    fb_scanout_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clock      (clock),
        .reset      (reset),
`ifdef TEST_PATTERN_EN
        .o_bar_c    (w_bar),
`endif
        .o_active_c (w_flags.active),
        .o_hsync_c  (w_flags.hsync),
        .o_vsync_c  (w_flags.vsync),
        .o_first_c  (w_flags.first)
    );

    // Address tracks the counters by stepping after each active pixel; it
    // wraps after the last pixel and therefore idles at 0 through vblank
    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr <= '0;
        end else if (w_flags.active) begin
            r_addr <= (r_addr == ADDR_W'(PIXELS - 1)) ? '0 : r_addr + ADDR_W'(1);
        end
    end

    // Flags ride a FB_LATENCY-deep shift register so they emerge with data_vga
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(FB_LATENCY); i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= w_flags;
            for (int i = 1; i < int'(FB_LATENCY); i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign w_emerge = r_pipe[FB_LATENCY-1];

`ifdef TEST_PATTERN_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(FB_LATENCY); i++) r_bar_pipe[i] <= '0;
        end else begin
            r_bar_pipe[0] <= w_bar;
            for (int i = 1; i < int'(FB_LATENCY); i++) r_bar_pipe[i] <= r_bar_pipe[i-1];
        end
    end
`else
    logic w_unused_tp;
    assign w_unused_tp = bus.test_pattern;
`endif

    // Palette expansion, blanked outside the visible window
    always_comb begin
        w_rgb = '0;
        if (w_emerge.active) begin
            w_rgb = PALETTE[bus.data_vga];
`ifdef TEST_PATTERN_EN
            if (bus.test_pattern) w_rgb = PALETTE[PIX_W'(r_bar_pipe[FB_LATENCY-1])];
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rgb         <= '0;
            r_de          <= 1'b0;
            r_hsync       <= SYNC_INV;
            r_vsync       <= SYNC_INV;
            r_frame_start <= 1'b0;
        end else begin
            r_rgb         <= w_rgb;
            r_de          <= w_emerge.active;
            r_hsync       <= w_emerge.hsync ^ SYNC_INV;
            r_vsync       <= w_emerge.vsync ^ SYNC_INV;
            r_frame_start <= w_emerge.first;
        end
    end

    assign bus.addr_vga    = r_addr;
    assign bus.rgb         = r_rgb;
    assign bus.de          = r_de;
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout: full-width lines with a shortened frame (4 visible lines) to keep runs short.
module tb_fb_scanout;

    localparam int unsigned HA    = 800;
    localparam int unsigned HFP   = 40;
    localparam int unsigned HS    = 128;
    localparam int unsigned HBP   = 88;
    localparam int unsigned HT    = HA + HFP + HS + HBP;
    localparam int unsigned VA    = 4;
    localparam int unsigned VFP   = 2;
    localparam int unsigned VS    = 3;
    localparam int unsigned VBP   = 2;
    localparam int unsigned VT    = VA + VFP + VS + VBP;
    localparam int unsigned PIX   = HA * VA;
    localparam int unsigned FRAME = HT * VT;
`ifdef TEST_PATTERN_EN
    localparam bit TP_ON = 1'b1;
`else
    localparam bit TP_ON = 1'b0;
`endif

    localparam logic [11:0] PAL [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA,
        12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF,
        12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fb_scanout_if u_if();

    fb_scanout #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .FB_LATENCY (3), .SYNC_ACTIVE_LOW (1)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (u_if)
    );

    // Framebuffer model: returns addr[3:0] three clocks after the address
    logic [18:0] d1, d2, d3;
    always_ff @(posedge clk) begin
        d1 <= u_if.addr_vga;
        d2 <= d1;
        d3 <= d2;
    end
    assign u_if.data_vga = d3[3:0];

    int checks = 0;
    int errors = 0;

    int m_addr, m_de, m_rgb, m_hs, m_vs, m_fs, first_bad;
    int first_de_t, de_run_min, de_run_max, line_per, hs_off;
    int hs_low_min, hs_low_max, vs_low, vs_per, fs_cnt, fs_no_de, wrap_cnt;
    logic [18:0] addr_line1;
    logic [11:0] rgb_x250;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string pfx);
        chk({pfx, "_addr"},  32'(u_if.addr_vga),    32'd0);
        chk({pfx, "_de"},    32'(u_if.de),          32'd0);
        chk({pfx, "_rgb"},   32'(u_if.rgb),         32'd0);
        chk({pfx, "_hsync"}, 32'(u_if.hsync),       32'd1);
        chk({pfx, "_vsync"}, 32'(u_if.vsync),       32'd1);
        chk({pfx, "_fs"},    32'(u_if.frame_start), 32'd0);
    endtask

    // Runs n clocks from reset release, comparing every cycle against the raster model
    task automatic sweep(input int n, input bit tp);
        int q, h, v, ph, pv, de_rise, hs_fall, vs_fall;
        logic [18:0] e_addr, paddr;
        logic [11:0] e_rgb;
        logic e_de, e_hs, e_vs, e_fs, pde, phs, pvs;
        pde = 1'b0; phs = 1'b1; pvs = 1'b1; paddr = '0;
        de_rise = -1; hs_fall = -1; vs_fall = -1;
        m_addr = 0; m_de = 0; m_rgb = 0; m_hs = 0; m_vs = 0; m_fs = 0; first_bad = -1;
        first_de_t = -1; de_run_min = 1 << 30; de_run_max = 0; line_per = 1 << 30; hs_off = -1;
        hs_low_min = 1 << 30; hs_low_max = 0; vs_low = -1; vs_per = -1;
        fs_cnt = 0; fs_no_de = 0; wrap_cnt = 0; addr_line1 = '1; rgb_x250 = '1;
        for (int t = 1; t <= n; t++) begin
            tick();
            ph = t % int'(HT);
            pv = (t / int'(HT)) % int'(VT);
            if (pv < int'(VA)) e_addr = (ph < int'(HA)) ? 19'(pv * int'(HA) + ph)
                                                        : 19'(((pv + 1) * int'(HA)) % int'(PIX));
            else               e_addr = '0;
            q = t - 4;
            if (q < 0) begin
                e_de = 1'b0; e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
            end else begin
                h = q % int'(HT);
                v = (q / int'(HT)) % int'(VT);
                e_de  = (h < int'(HA)) && (v < int'(VA));
                e_rgb = !e_de ? 12'h000 : (tp ? PAL[4'(h / 100)] : PAL[4'((v * int'(HA) + h) % 16)]);
                e_hs  = !((h >= int'(HA + HFP)) && (h < int'(HA + HFP + HS)));
                e_vs  = !((v >= int'(VA + VFP)) && (v < int'(VA + VFP + VS)));
                e_fs  = (h == 0) && (v == 0);
            end
            if (u_if.addr_vga !== e_addr)  begin m_addr++; if (first_bad < 0) first_bad = t; end
            if (u_if.de !== e_de)          begin m_de++;   if (first_bad < 0) first_bad = t; end
            if (u_if.rgb !== e_rgb)        begin m_rgb++;  if (first_bad < 0) first_bad = t; end
            if (u_if.hsync !== e_hs)       begin m_hs++;   if (first_bad < 0) first_bad = t; end
            if (u_if.vsync !== e_vs)       begin m_vs++;   if (first_bad < 0) first_bad = t; end
            if (u_if.frame_start !== e_fs) begin m_fs++;   if (first_bad < 0) first_bad = t; end

            if (u_if.de && !pde) begin
                if (first_de_t < 0) first_de_t = t;
                if (de_rise >= 0 && (t - de_rise) < line_per) line_per = t - de_rise;
                de_rise = t;
            end
            if (!u_if.de && pde && de_rise >= 0) begin
                if ((t - de_rise) < de_run_min) de_run_min = t - de_rise;
                if ((t - de_rise) > de_run_max) de_run_max = t - de_rise;
            end
            if (!u_if.hsync && phs) begin
                hs_fall = t;
                if (hs_off < 0 && de_rise >= 0) hs_off = t - de_rise;
            end
            if (u_if.hsync && !phs && hs_fall >= 0) begin
                if ((t - hs_fall) < hs_low_min) hs_low_min = t - hs_fall;
                if ((t - hs_fall) > hs_low_max) hs_low_max = t - hs_fall;
            end
            if (!u_if.vsync && pvs) begin
                if (vs_fall >= 0) vs_per = t - vs_fall;
                vs_fall = t;
            end
            if (u_if.vsync && !pvs && vs_fall >= 0) vs_low = t - vs_fall;
            if (u_if.frame_start) begin
                fs_cnt++;
                if (!u_if.de) fs_no_de++;
            end
            if (paddr == 19'(PIX - 1) && u_if.addr_vga == '0) wrap_cnt++;
            if (t == int'(HT)) addr_line1 = u_if.addr_vga;
            if (q == 250) rgb_x250 = u_if.rgb;
            pde = u_if.de; phs = u_if.hsync; pvs = u_if.vsync; paddr = u_if.addr_vga;
        end
    endtask

    task automatic chk_sweep(input string pfx);
        if (first_bad >= 0) $display("%s: first deviating cycle after release = %0d", pfx, first_bad);
        chk({pfx, "_addr_seq"},  32'(m_addr), 32'd0);
        chk({pfx, "_de_seq"},    32'(m_de),   32'd0);
        chk({pfx, "_rgb_seq"},   32'(m_rgb),  32'd0);
        chk({pfx, "_hsync_seq"}, 32'(m_hs),   32'd0);
        chk({pfx, "_vsync_seq"}, 32'(m_vs),   32'd0);
        chk({pfx, "_fs_seq"},    32'(m_fs),   32'd0);
        chk({pfx, "_first_de"},  32'(first_de_t), 32'd4);
    endtask

    initial begin
        rst = 1'b1;
        u_if.test_pattern = 1'b0;
        repeat (5) tick();
        chk_reset_state("por");

        // Two full frames from a clean release
        rst = 1'b0;
        sweep(int'(2 * FRAME + 2), 1'b0);
        chk_sweep("run1");
        chk("de_run_min",   32'(de_run_min), 32'd800);
        chk("de_run_max",   32'(de_run_max), 32'd800);
        chk("line_period",  32'(line_per),   32'd1056);
        chk("hsync_offset", 32'(hs_off),     32'd840);
        chk("hsync_low_min", 32'(hs_low_min), 32'd128);
        chk("hsync_low_max", 32'(hs_low_max), 32'd128);
        chk("vsync_low",    32'(vs_low),     32'd3168);
        chk("frame_period", 32'(vs_per),     32'd11616);
        chk("fs_count",     32'(fs_cnt),     32'd2);
        chk("fs_without_de", 32'(fs_no_de),  32'd0);
        chk("addr_line1",   32'(addr_line1), 32'd800);
        chk("addr_wraps",   32'(wrap_cnt),   32'd2);
        chk("rgb_x250_plain", 32'(rgb_x250), 32'(PAL[10]));

        // Restart with test_pattern requested, then abandon the frame at line 2, x=417
        rst = 1'b1;
        u_if.test_pattern = 1'b1;
        tick();
        chk_reset_state("rst2");
        rst = 1'b0;
        sweep(int'(2 * HT + 417), TP_ON);
        chk_sweep("run2");
        chk("rgb_x250_tp", 32'(rgb_x250), TP_ON ? 32'(PAL[2]) : 32'(PAL[10]));
        chk("pre_reset_de", 32'(u_if.de), 32'd1);
        rst = 1'b1;
        tick();
        chk_reset_state("mid");
        tick();
        tick();
        rst = 1'b0;
        sweep(int'(FRAME + 2), TP_ON);
        chk_sweep("run3");
        chk("run3_fs_count",    32'(fs_cnt),   32'd1);
        chk("run3_line_period", 32'(line_per), 32'd1056);
        chk("run3_frame_vsync", 32'(vs_low),   32'd3168);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
